ou_link_fifo: RTL and testbench

Elastic buffer placed on an RCA interconnect path between a producing operation unit (e.g. the signed-compare OU) and the consuming OU input. It accepts results through the OU valid/ack handshake, stores up to DEPTH words in order, and presents them to the consumer through the same handshake. It decouples producer and consumer stalls so a slow consumer does not hold the producer's inputs.

---
 rtl/ou_link_fifo_if.sv | 16 +
 rtl/ou_link_fifo.sv | 70 +++++++
 tb/tb_ou_link_fifo.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ou_link_fifo_if.sv
// ou_link_fifo_if: one direction of an OU valid/ack link.
//   data  : result word, driven by the sender
//   valid : word on data is valid, driven by the sender
//   ack   : receiver took the word this cycle, driven by the receiver
// A transfer happens in exactly the cycles where valid and ack are both high.
// The master modport is the sending side. The slave modport is the receiving side.
interface ou_link_fifo_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] data;
   logic            valid;
   logic            ack;

   modport master (output data, output valid, input ack);
   modport slave  (input data, input valid, output ack);
endinterface

// File: rtl/ou_link_fifo.sv
// ou_link_fifo: elastic buffer between a producing OU and a consuming OU input.
// It stores up to DEPTH words in order and decouples producer stalls from
// consumer stalls.
//   clk                : clock; all state updates on the rising edge
//   rst                : synchronous active-high reset
//   flush              : drop every stored entry
//   consumer_uses_data : the consumer port is in use; when low, producer words
//                        are acked and discarded, and stored entries are hidden
//   prod (slave)       : producer link (data_in / data_valid_in / data_in_ack)
//   cons (master)      : consumer link (data_out / data_valid_out / data_out_ack)
//   count              : occupancy, 0..DEPTH
module ou_link_fifo #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       consumer_uses_data,
   ou_link_fifo_if.slave              prod,
   ou_link_fifo_if.master             cons,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [XLEN-1:0] storage [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic            full;
   logic            push;
   logic            pop;
   logic            discard;

   // Full is taken from the registered count only. This keeps data_out_ack
   // off the data_in_ack path, so a pop frees its slot for the next cycle.
   assign full    = (count == CW'(DEPTH));
   assign push    = prod.valid && !full && consumer_uses_data && !flush && !rst;
   assign discard = prod.valid && !consumer_uses_data && !flush && !rst;
   assign prod.ack = push || discard;

   assign cons.valid = (count != '0) && consumer_uses_data;
   assign cons.data  = storage[rd_ptr];
   assign pop        = cons.ack && cons.valid && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage holds data only; validity comes from count, so it has no reset.
   always_ff @(posedge clk) begin
      if (push) storage[wr_ptr] <= prod.data;
   end
endmodule

// File: tb/tb_ou_link_fifo.sv
// tb_ou_link_fifo: directed test of ou_link_fifo against a queue-based model.
module tb_ou_link_fifo;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       uses;
   logic [2:0] count;
   logic       chk_en = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] q[$];

   ou_link_fifo_if #(.XLEN(XLEN)) prod_if ();
   ou_link_fifo_if #(.XLEN(XLEN)) cons_if ();

   ou_link_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .flush              (flush),
      .consumer_uses_data (uses),
      .prod               (prod_if),
      .cons               (cons_if),
      .count              (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model state update: a queue of stored words.
   always @(posedge clk) begin
      bit do_pop, do_push;
      do_pop  = cons_if.ack && uses && q.size() != 0 && !flush;
      do_push = prod_if.valid && uses && q.size() < DEPTH && !flush;
      if (rst || flush) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(prod_if.data);
      end
   end

   // Every-cycle compare of the DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic exp_ack, exp_valid;
         exp_ack   = !rst && !flush && prod_if.valid && (!uses || q.size() < DEPTH);
         exp_valid = uses && q.size() != 0;
         chk("m_ack", 32'(prod_if.ack), 32'(exp_ack));
         chk("m_valid", 32'(cons_if.valid), 32'(exp_valid));
         chk("m_count", 32'(count), 32'(q.size()));
         if (exp_valid) chk("m_data", cons_if.data, q[0]);
      end
   end

   task automatic step(input logic vin, input logic [31:0] d, input logic oack,
                       input logic u, input logic fl, input logic r);
      @(posedge clk);
      #1;
      prod_if.valid = vin;
      prod_if.data  = d;
      cons_if.ack   = oack;
      uses          = u;
      flush         = fl;
      rst           = r;
      @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && q.size() != 0; i++) step(0, 0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("drain_empty", 32'(count), 32'd0);
   endtask

   initial begin
      logic [31:0] fill_vals [4];
      fill_vals[0] = 32'hA; fill_vals[1] = 32'hB;
      fill_vals[2] = 32'hC; fill_vals[3] = 32'hD;

      rst = 1'b1; flush = 1'b0; uses = 1'b1;
      prod_if.valid = 1'b0; prod_if.data = '0; cons_if.ack = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(cons_if.valid), 32'd0);
      step(0, 0, 0, 1, 0, 0);

      // Fill with the consumer stalled, then drain.
      for (int i = 0; i < 4; i++) begin
         step(1, fill_vals[i], 0, 1, 0, 0);
         chk("fill_ack", 32'(prod_if.ack), 32'd1);
      end
      step(1, 32'hE, 0, 1, 0, 0);
      chk("full_count", 32'(count), 32'd4);
      chk("full_ack", 32'(prod_if.ack), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 1, 0, 0);
         chk("drain_data", cons_if.data, fill_vals[i]);
      end
      step(0, 0, 0, 1, 0, 0);
      chk("drained_count", 32'(count), 32'd0);

      // Full with a simultaneous pop: the push waits one cycle.
      for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, 1, 0, 0);
      step(1, 32'h55, 1, 1, 0, 0);
      chk("fs_ack0", 32'(prod_if.ack), 32'd0);
      chk("fs_count0", 32'(count), 32'd4);
      step(1, 32'h55, 0, 1, 0, 0);
      chk("fs_ack1", 32'(prod_if.ack), 32'd1);
      chk("fs_count1", 32'(count), 32'd3);
      step(0, 0, 0, 1, 0, 0);
      chk("fs_count2", 32'(count), 32'd4);
      chk("fs_head", cons_if.data, 32'h2);
      drain();

      // Streaming 64 words with the consumer acking every cycle.
      for (int i = 0; i < 64; i++) begin
         step(1, 32'h100 + 32'(i), 1, 1, 0, 0);
         if (i == 0) chk("st_count0", 32'(count), 32'd0);
         else begin
            chk("st_valid", 32'(cons_if.valid), 32'd1);
            chk("st_data", cons_if.data, 32'h100 + 32'(i - 1));
            chk("st_count", 32'(count), 32'd1);
         end
      end
      step(0, 0, 1, 1, 0, 0);
      chk("st_last", cons_if.data, 32'h13F);
      step(0, 0, 0, 1, 0, 0);
      chk("st_empty", 32'(count), 32'd0);

      // Flush beats both a push and a pop.
      for (int i = 0; i < 3; i++) step(1, 32'h21 + 32'(i), 0, 1, 0, 0);
      step(1, 32'h24, 1, 1, 1, 0);
      chk("fl_ack", 32'(prod_if.ack), 32'd0);
      chk("fl_count_pre", 32'(count), 32'd3);
      step(0, 0, 0, 1, 0, 0);
      chk("fl_count", 32'(count), 32'd0);
      chk("fl_valid", 32'(cons_if.valid), 32'd0);
      step(1, 32'h7, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("fl_head_valid", 32'(cons_if.valid), 32'd1);
      chk("fl_head", cons_if.data, 32'h7);
      drain();

      // Unused port: words are acked and discarded, held entries are hidden.
      step(1, 32'h31, 0, 1, 0, 0);
      step(1, 32'h32, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h99, 1, 0, 0, 0);
         chk("un_ack", 32'(prod_if.ack), 32'd1);
         chk("un_valid", 32'(cons_if.valid), 32'd0);
         chk("un_count", 32'(count), 32'd2);
      end
      step(0, 0, 1, 1, 0, 0);
      chk("un_head0", cons_if.data, 32'h31);
      chk("un_valid0", 32'(cons_if.valid), 32'd1);
      step(0, 0, 1, 1, 0, 0);
      chk("un_head1", cons_if.data, 32'h32);
      step(0, 0, 0, 1, 0, 0);
      chk("un_empty", 32'(count), 32'd0);
      step(1, 32'h98, 0, 0, 0, 0);
      chk("un_ack_empty", 32'(prod_if.ack), 32'd1);
      step(0, 0, 0, 0, 0, 0);
      chk("un_count_empty", 32'(count), 32'd0);

      // Reset mid-operation.
      step(1, 32'h41, 0, 1, 0, 0);
      step(1, 32'h42, 0, 1, 0, 0);
      step(1, 32'h43, 0, 1, 0, 1);
      chk("rm_ack0", 32'(prod_if.ack), 32'd0);
      chk("rm_count_pre", 32'(count), 32'd2);
      step(1, 32'h43, 0, 1, 0, 1);
      chk("rm_count", 32'(count), 32'd0);
      chk("rm_valid", 32'(cons_if.valid), 32'd0);
      chk("rm_ack1", 32'(prod_if.ack), 32'd0);
      step(0, 0, 0, 1, 0, 0);
      chk("rm_count_post", 32'(count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
